// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg -- shared types for the sequential ALU (alu_seq / alu_muldiv).
//
// Contents:
//   alu_op_e      : 4-bit opcode encoding driven on alu_seq.ALUCtl
//   alu_state_e   : top-level control FSM states
//   is_iterative(): true for opcodes executed by the bit-serial mul/div unit
//
// Build option:
//   ALU_SEQ_DIV_EN : when defined, DIVU/REMU are iterative operations;
//                    otherwise they are treated as illegal opcodes.
// -----------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SLT   = 4'd5,
    OP_SLTU  = 4'd6,
    OP_SLL   = 4'd7,
    OP_SRL   = 4'd8,
    OP_SRA   = 4'd9,
    OP_MUL   = 4'd10,
    OP_MULHU = 4'd11,
    OP_DIVU  = 4'd12,
    OP_REMU  = 4'd13
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  // Opcodes that go through the one-bit-per-cycle datapath.
  function automatic logic is_iterative(input logic [3:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_MUL, OP_MULHU: r = 1'b1;
`ifdef ALU_SEQ_DIV_EN
      OP_DIVU, OP_REMU: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_muldiv.sv
// -----------------------------------------------------------------------------
// alu_muldiv -- iterative shift-add multiplier and restoring divider.
//
// One bit is processed per clock; an operation takes DATA_WIDTH clocks after
// i_start. o_done is asserted combinationally during the final iteration and
// o_result carries the value that iteration produces, so the caller can
// register it on the same edge the datapath finishes.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_start     : launch an operation with i_op / i_a / i_b (ignored if busy)
//   i_op        : OP_MUL, OP_MULHU, (OP_DIVU, OP_REMU with ALU_SEQ_DIV_EN)
//   i_a, i_b    : operands (multiplicand/multiplier or dividend/divisor)
//   o_done      : final iteration in progress, o_result valid this cycle
//   o_result    : selected half of product, or quotient / remainder
//
// Build option:
//   ALU_SEQ_DIV_EN : include the restoring divider; without it no divider
//                    logic exists and only the multiplier is built.
// -----------------------------------------------------------------------------
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  alu_op_e               i_op,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic          r_busy;
  logic [CW-1:0] r_cnt;
  alu_op_e       r_op;
  // Multiply: r_opnd = multiplicand, {r_hi, r_lo} = running product with the
  //           unconsumed multiplier bits in the low end of r_lo.
  // Divide:   r_opnd = divisor, r_hi = partial remainder, r_lo = dividend bits
  //           shifting out the top while quotient bits shift in at the bottom.
  logic [W-1:0]  r_opnd;
  logic [W-1:0]  r_hi;
  logic [W-1:0]  r_lo;

  logic [W:0]    w_mul_sum;
  logic [W-1:0]  w_hi_next;
  logic [W-1:0]  w_lo_next;
  logic          w_is_div;
  logic          w_start_div;

`ifdef ALU_SEQ_DIV_EN
  logic [W:0]    w_div_shift;
  logic          w_div_ge;

  assign w_is_div    = (r_op == OP_DIVU) || (r_op == OP_REMU);
  assign w_start_div = (i_op == OP_DIVU) || (i_op == OP_REMU);
`else
  assign w_is_div    = 1'b0;
  assign w_start_div = 1'b0;
`endif

  // One iteration of whichever algorithm is loaded.
  always_comb begin
    w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(W+1){1'b0}});
    w_hi_next = w_mul_sum[W:1];
    w_lo_next = {w_mul_sum[0], r_lo[W-1:1]};
`ifdef ALU_SEQ_DIV_EN
    // Partial remainder is always below the divisor, so the shifted value
    // fits in W+1 bits and the kept remainder fits back into W bits. A zero
    // divisor makes every trial succeed: quotient all-ones, remainder = A.
    w_div_shift = {r_hi, r_lo[W-1]};
    w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
    if (w_is_div) begin
      w_hi_next = w_div_ge ? W'(w_div_shift - {1'b0, r_opnd}) : w_div_shift[W-1:0];
      w_lo_next = {r_lo[W-2:0], w_div_ge};
    end
`endif
  end

  assign o_done = r_busy && (r_cnt == LAST);

  always_comb begin
    o_result = '0;
    case (r_op)
      OP_MUL:   o_result = w_lo_next;
      OP_MULHU: o_result = w_hi_next;
`ifdef ALU_SEQ_DIV_EN
      OP_DIVU:  o_result = w_lo_next;
      OP_REMU:  o_result = w_hi_next;
`endif
      default:  o_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_op   <= OP_ADD;
      r_opnd <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else if (i_start && !r_busy) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_op   <= i_op;
      r_hi   <= '0;
      if (w_start_div) begin
        r_opnd <= i_b;
        r_lo   <= i_a;
      end else begin
        r_opnd <= i_a;
        r_lo   <= i_b;
      end
    end else if (r_busy) begin
      r_hi <= w_hi_next;
      r_lo <= w_lo_next;
      if (o_done) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- sequential ALU with valid/ready handshakes on both sides.
//
// Single-cycle ops (ADD..SRA, illegal opcodes) present their result the cycle
// after acceptance. MUL/MULHU (and DIVU/REMU when enabled) run in alu_muldiv
// and present their result DATA_WIDTH+1 cycles after acceptance.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_valid    : request present on A/B/ALUCtl
//   in_ready    : request accepted on this edge if in_valid is high
//   A, B        : operands (shift amount = B[$clog2(DATA_WIDTH)-1:0])
//   ALUCtl      : opcode, see alu_pkg::alu_op_e
//   out_valid   : Result/Zero valid, held until out_ready
//   out_ready   : consumer takes the result
//   Result      : registered result
//   Zero        : Result == 0
//
// Build option:
//   ALU_SEQ_DIV_EN : enables DIVU/REMU; otherwise opcodes 12/13 return 0
//                    with single-cycle latency.
// -----------------------------------------------------------------------------
module alu_seq
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [3:0]            ALUCtl,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  Zero
);

  localparam int W   = DATA_WIDTH;
  localparam int SHW = $clog2(W);

  alu_state_e   r_state;
  alu_state_e   w_state_next;
  logic [W-1:0] r_result;

  alu_op_e      w_op;
  logic         w_iterative;
  logic         w_accept;
  logic         w_md_start;
  logic         w_md_done;
  logic [W-1:0] w_md_result;
  logic [W-1:0] w_alu_result;
  logic [SHW-1:0] w_shamt;

  assign w_op        = alu_op_e'(ALUCtl);
  assign w_iterative = is_iterative(ALUCtl);
  assign w_shamt     = B[SHW-1:0];

  // Single-cycle datapath, evaluated on the live inputs and captured into
  // r_result on the accept edge.
  always_comb begin
    w_alu_result = '0;
    case (w_op)
      OP_ADD:  w_alu_result = A + B;
      OP_SUB:  w_alu_result = A - B;
      OP_AND:  w_alu_result = A & B;
      OP_OR:   w_alu_result = A | B;
      OP_XOR:  w_alu_result = A ^ B;
      OP_SLT:  w_alu_result = {{(W-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: w_alu_result = {{(W-1){1'b0}}, (A < B)};
      OP_SLL:  w_alu_result = A << w_shamt;
      OP_SRL:  w_alu_result = A >> w_shamt;
      OP_SRA:  w_alu_result = $signed(A) >>> w_shamt;
      default: w_alu_result = '0;
    endcase
  end

  alu_muldiv #(
    .DATA_WIDTH (W)
  ) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_md_start),
    .i_op     (w_op),
    .i_a      (A),
    .i_b      (B),
    .o_done   (w_md_done),
    .o_result (w_md_result)
  );

  // Control FSM: next state and handshake outputs.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    w_md_start   = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
      end
      ST_BUSY: begin
        if (w_md_done) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        // A new request may only enter while the current result leaves.
        in_ready  = out_ready;
        if (out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
    w_accept = in_valid && in_ready;
    if (w_accept) begin
      w_state_next = w_iterative ? ST_BUSY : ST_DONE;
      w_md_start   = w_iterative;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
    end else if (w_accept && !w_iterative) begin
      r_result <= w_alu_result;
    end else if ((r_state == ST_BUSY) && w_md_done) begin
      r_result <= w_md_result;
    end
  end

  assign Result = r_result;
  assign Zero   = (r_result == '0);

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  localparam int W = 32;
`ifdef ALU_SEQ_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic [3:0]    ALUCtl;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  Result;
  logic          Zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .ALUCtl    (ALUCtl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .Zero      (Zero)
  );

  // Reference model: plain arithmetic on the architectural definition.
  function automatic logic [31:0] ref_result(input logic [3:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] wide;
    logic [63:0] ext;
    int unsigned sh;
    sh = int'(b[4:0]);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:  return (a < b) ? 32'd1 : 32'd0;
      4'd7:  return a << sh;
      4'd8:  return a >> sh;
      4'd9: begin
        ext = {{32{a[31]}}, a};
        ext = ext >> sh;
        return ext[31:0];
      end
      4'd10: begin
        wide = 64'(a) * 64'(b);
        return wide[31:0];
      end
      4'd11: begin
        wide = 64'(a) * 64'(b);
        return wide[63:32];
      end
      4'd12: begin
        if (!DIV_EN) return 32'd0;
        return (b == 0) ? 32'hFFFF_FFFF : a / b;
      end
      4'd13: begin
        if (!DIV_EN) return 32'd0;
        return (b == 0) ? a : a % b;
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] op);
    if (op == 4'd10 || op == 4'd11) return W + 1;
    if (DIV_EN && (op == 4'd12 || op == 4'd13)) return W + 1;
    return 1;
  endfunction

  // Issue one operation (called at a falling edge), wait for its result with
  // out_ready low, check it, then consume it.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input string tag);
    int   lat;
    int   wait_n;
    int   exp_lat;
    logic saw_ready;
    exp_lat = ref_latency(op);
    A = a; B = b; ALUCtl = op; in_valid = 1'b1; out_ready = 1'b0;
    wait_n = 0;
    while (!in_ready && wait_n < 200) begin
      @(negedge clk);
      wait_n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s accept_timeout in_ready=%b required 1", tag, in_ready);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    // Scramble inputs: the captured operation must not be affected.
    in_valid = 1'b0; A = $urandom; B = $urandom; ALUCtl = 4'($urandom);
    lat = 1;
    saw_ready = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) saw_ready = 1'b1;
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s latency got=%0d required=%0d", tag, lat, exp_lat);
    end
    checks++;
    if (Result !== exp) begin
      errors++;
      $display("FAIL %s result got=%h required=%h", tag, Result, exp);
    end
    checks++;
    if (Zero !== (exp == 32'd0)) begin
      errors++;
      $display("FAIL %s zero got=%b required=%b", tag, Zero, (exp == 32'd0));
    end
    if (exp_lat > 1) begin
      checks++;
      if (saw_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s in_ready_busy got=1 required=0", tag);
      end
    end
    $display("txn %s op=%0d A=%h B=%h Result=%h Zero=%b lat=%0d", tag, op, a, b, Result, Zero, lat);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s drain out_valid=%b required 0", tag, out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; ALUCtl = '0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || Result !== 32'd0 || Zero !== 1'b1) begin
      errors++;
      $display("FAIL reset_state out_valid=%b Result=%h Zero=%b required 0/0/1", out_valid, Result, Zero);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    $display("txn reset in_ready=%b out_valid=%b Result=%h Zero=%b", in_ready, out_valid, Result, Zero);
  endtask

  task automatic test_directed();
    run_op(4'd0,  32'hFFFF_FFFF, 32'd1,        32'd0,         "add_wrap");
    run_op(4'd5,  32'hFFFF_FFFE, 32'd1,        32'd1,         "slt");
    run_op(4'd6,  32'hFFFF_FFFE, 32'd1,        32'd0,         "sltu");
    run_op(4'd9,  32'h8000_0000, 32'h24,       32'hF800_0000, "sra");
    run_op(4'd10, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, "mul");
    run_op(4'd11, 32'h0001_0001, 32'h0001_0001, 32'h0000_0001, "mulhu");
    run_op(4'd12, 32'd100, 32'd7, DIV_EN ? 32'd14 : 32'd0,         "divu");
    run_op(4'd13, 32'd100, 32'd7, DIV_EN ? 32'd2 : 32'd0,          "remu");
    run_op(4'd12, 32'd5,   32'd0, DIV_EN ? 32'hFFFF_FFFF : 32'd0,  "divu_zero");
    run_op(4'd13, 32'd5,   32'd0, DIV_EN ? 32'd5 : 32'd0,          "remu_zero");
    run_op(4'd14, 32'h1234_5678, 32'h1, 32'd0,                     "illegal14");
    run_op(4'd15, 32'h1234_5678, 32'h1, 32'd0,                     "illegal15");
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 30; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      run_op(op, a, b, ref_result(op, a, b), "rand");
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp1;
    logic [31:0] exp2;
    logic        bad;
    exp1 = ref_result(4'd0, 32'h0000_1111, 32'h0000_2222);
    exp2 = ref_result(4'd1, 32'h0000_0050, 32'h0000_0008);
    A = 32'h0000_1111; B = 32'h0000_2222; ALUCtl = 4'd0;
    in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    // Second request waits while the first result is stalled.
    A = 32'h0000_0050; B = 32'h0000_0008; ALUCtl = 4'd1;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || Result !== exp1 || in_ready !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL stall_hold out_valid=%b Result=%h in_ready=%b required 1/%h/0", out_valid, Result, in_ready, exp1);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || Result !== exp2) begin
      errors++;
      $display("FAIL b2b_result out_valid=%b Result=%h required 1/%h", out_valid, Result, exp2);
    end
    $display("txn back_to_back first=%h second=%h Result=%h", exp1, exp2, Result);
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_mul();
    logic stale;
    A = 32'h0001_0001; B = 32'h0001_0001; ALUCtl = 4'd10;
    in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mul_busy in_ready=%b required 0", in_ready);
    end
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || Result !== 32'd0 || Zero !== 1'b1) begin
      errors++;
      $display("FAIL abort_state out_valid=%b Result=%h Zero=%b required 0/0/1", out_valid, Result, Zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_ready in_ready=%b required 1", in_ready);
    end
    out_ready = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    out_ready = 1'b0;
    checks++;
    if (stale !== 1'b0) begin
      errors++;
      $display("FAIL abort_stale out_valid seen=1 required 0");
    end
    $display("txn reset_mid_mul in_ready=%b stale=%b", in_ready, stale);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_mul();
    // Block must be fully usable again after the abort.
    @(negedge clk);
    run_op(4'd10, 32'd3, 32'd5, 32'd15, "mul_after_abort");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
